// File: rtl/rename_stage_pkg.sv
// rename_stage_pkg: shared widths, register-index types and the RAT reset map
//   NUM_LREG / LREG_WIDTH / PREG_WIDTH : architectural and physical register sizing
//   arch_preg_init(i)                  : physical register mapped to lreg i after reset
package rename_stage_pkg;
   localparam int NUM_LREG   = 32;
   localparam int LREG_WIDTH = 5;
   localparam int PREG_WIDTH = 6;
   typedef logic [LREG_WIDTH-1:0] lreg_t;
   typedef logic [PREG_WIDTH-1:0] preg_t;
   function automatic preg_t arch_preg_init(input int i);
      return preg_t'(i);
   endfunction
endpackage

// File: rtl/rename_stage_if.sv
// rename_stage_if: decode-in, freelist, ROB-walk and dispatch-out signal bundle
//   slave  : rename stage side (consumes decode/freelist/walk, drives out_*, in_ready, fl_rd_en*)
//   master : environment side (decode, freelist, ROB and dispatch)
interface rename_stage_if;
   import rename_stage_pkg::*;
   logic  in_valid, in_ready, in_v0, in_v1, in_wen_0, in_wen_1;
   lreg_t in_lrs1_0, in_lrs1_1, in_lrs2_0, in_lrs2_1, in_lrd_0, in_lrd_1;
   logic [5:0] fl_free_cnt;
   logic  fl_rd_en0, fl_rd_en1;
   preg_t fl_rd_data0, fl_rd_data1;
   logic  is_rollingback, is_walking, walking_valid0, walking_valid1;
   lreg_t walking_lrd0, walking_lrd1;
   preg_t walking_old_prd0, walking_old_prd1;
   logic  out_valid, out_ready, out_v0, out_v1;
   preg_t out_prs1_0, out_prs1_1, out_prs2_0, out_prs2_1;
   preg_t out_prd_0, out_prd_1, out_old_prd_0, out_old_prd_1;
   modport slave (
      input  in_valid, in_v0, in_v1, in_wen_0, in_wen_1,
             in_lrs1_0, in_lrs1_1, in_lrs2_0, in_lrs2_1, in_lrd_0, in_lrd_1,
             fl_free_cnt, fl_rd_data0, fl_rd_data1,
             is_rollingback, is_walking, walking_valid0, walking_valid1,
             walking_lrd0, walking_lrd1, walking_old_prd0, walking_old_prd1, out_ready,
      output in_ready, fl_rd_en0, fl_rd_en1, out_valid, out_v0, out_v1,
             out_prs1_0, out_prs1_1, out_prs2_0, out_prs2_1,
             out_prd_0, out_prd_1, out_old_prd_0, out_old_prd_1
   );
   modport master (
      output in_valid, in_v0, in_v1, in_wen_0, in_wen_1,
             in_lrs1_0, in_lrs1_1, in_lrs2_0, in_lrs2_1, in_lrd_0, in_lrd_1,
             fl_free_cnt, fl_rd_data0, fl_rd_data1,
             is_rollingback, is_walking, walking_valid0, walking_valid1,
             walking_lrd0, walking_lrd1, walking_old_prd0, walking_old_prd1, out_ready,
      input  in_ready, fl_rd_en0, fl_rd_en1, out_valid, out_v0, out_v1,
             out_prs1_0, out_prs1_1, out_prs2_0, out_prs2_1,
             out_prd_0, out_prd_1, out_old_prd_0, out_old_prd_1
   );
endinterface

// File: rtl/rename_stage_spec_rat.sv
// rename_stage_spec_rat: speculative RAT, 32 x preg, combinational reads, rename and walk writes
//   clock, reset          : clock, synchronous active-high reset to arch_preg_init map
//   raddr[6] / rdata[6]   : combinational read ports (pre-update contents)
//   ren/rlrd/rprd[2]      : rename writes; slot1 overrides slot0 on equal lreg
//   wen/wlrd/wprd[2]      : walk restores; slot1 (older) overrides slot0 on equal lreg
module rename_stage_spec_rat
   import rename_stage_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  lreg_t [5:0]     raddr,
   output preg_t [5:0]     rdata,
   input  logic  [1:0]     ren,
   input  lreg_t [1:0]     rlrd,
   input  preg_t [1:0]     rprd,
   input  logic  [1:0]     wen,
   input  lreg_t [1:0]     wlrd,
   input  preg_t [1:0]     wprd
);
   preg_t rat [NUM_LREG];
   always_comb
      for (int j = 0; j < 6; j++) rdata[j] = rat[raddr[j]];
   // Later slot assignments land last, giving slot1 priority; x0 is never written.
   always_ff @(posedge clock)
      if (reset)
         for (int i = 0; i < NUM_LREG; i++) rat[i] <= arch_preg_init(i);
      else begin
         for (int k = 0; k < 2; k++)
            if (ren[k] && rlrd[k] != '0) rat[rlrd[k]] <= rprd[k];
         for (int k = 0; k < 2; k++)
            if (wen[k] && wlrd[k] != '0) rat[wlrd[k]] <= wprd[k];
      end
endmodule

// File: rtl/rename_stage.sv
// rename_stage: 2-wide register rename with freelist allocation, intra-group bypass and ROB-walk restore
//   clock, reset : clock, synchronous active-high reset
//   io (slave)   : decode group in, freelist pop/data, walk restore, registered dispatch group out
//   RENAME_PERF_CNT_EN : adds perf_stall_fl, perf_stall_bp, perf_renamed counters
module rename_stage
   import rename_stage_pkg::*;
(
   input logic           clock,
   input logic           reset,
   rename_stage_if.slave io
`ifdef RENAME_PERF_CNT_EN
   ,
   output logic [31:0]   perf_stall_fl,
   output logic [31:0]   perf_stall_bp,
   output logic [31:0]   perf_renamed
`endif
);
   logic need0, need1, fire, fl_ok;
   logic [1:0] alloc_cnt;
   preg_t prd0, prd1, prs1_0, prs2_0, prs1_1, prs2_1, old0, old1;
   preg_t [5:0] rd;
   assign need0 = io.in_v0 & io.in_wen_0 & (io.in_lrd_0 != '0);
   assign need1 = io.in_v1 & io.in_wen_1 & (io.in_lrd_1 != '0);
   assign alloc_cnt = {1'b0, need0} + {1'b0, need1};
   assign fl_ok = io.fl_free_cnt >= {4'd0, alloc_cnt};
   assign io.in_ready = ~reset & ~io.is_rollingback & ~io.is_walking & (~io.out_valid | io.out_ready) & fl_ok;
   assign fire = io.in_valid & io.in_ready;
   assign io.fl_rd_en0 = fire & (need0 | need1);
   assign io.fl_rd_en1 = fire & need0 & need1;
   // A lone allocation always takes data0, whichever slot needs it.
   assign prd0 = need0 ? io.fl_rd_data0 : '0;
   assign prd1 = need1 ? (need0 ? io.fl_rd_data1 : io.fl_rd_data0) : '0;
   assign prs1_0 = io.in_lrs1_0 == '0 ? '0 : rd[0];
   assign prs2_0 = io.in_lrs2_0 == '0 ? '0 : rd[1];
   assign prs1_1 = io.in_lrs1_1 == '0 ? '0 : (need0 && io.in_lrs1_1 == io.in_lrd_0) ? prd0 : rd[2];
   assign prs2_1 = io.in_lrs2_1 == '0 ? '0 : (need0 && io.in_lrs2_1 == io.in_lrd_0) ? prd0 : rd[3];
   assign old0 = need0 ? rd[4] : '0;
   assign old1 = !need1 ? '0 : (need0 && io.in_lrd_1 == io.in_lrd_0) ? prd0 : rd[5];
   rename_stage_spec_rat u_rat (
      .clock (clock),
      .reset (reset),
      .raddr ({io.in_lrd_1, io.in_lrd_0, io.in_lrs2_1, io.in_lrs1_1, io.in_lrs2_0, io.in_lrs1_0}),
      .rdata (rd),
      .ren   ({fire & need1, fire & need0}),
      .rlrd  ({io.in_lrd_1, io.in_lrd_0}),
      .rprd  ({prd1, prd0}),
      .wen   ({io.is_walking & io.walking_valid1, io.is_walking & io.walking_valid0}),
      .wlrd  ({io.walking_lrd1, io.walking_lrd0}),
      .wprd  ({io.walking_old_prd1, io.walking_old_prd0})
   );
   always_ff @(posedge clock)
      if (reset) begin
         io.out_valid     <= 1'b0;
         io.out_v0        <= 1'b0;
         io.out_v1        <= 1'b0;
         io.out_prs1_0    <= '0;
         io.out_prs2_0    <= '0;
         io.out_prs1_1    <= '0;
         io.out_prs2_1    <= '0;
         io.out_prd_0     <= '0;
         io.out_prd_1     <= '0;
         io.out_old_prd_0 <= '0;
         io.out_old_prd_1 <= '0;
      end else if (io.is_rollingback || io.is_walking) begin
         io.out_valid <= 1'b0;
         io.out_v0    <= 1'b0;
         io.out_v1    <= 1'b0;
      end else if (fire) begin
         io.out_valid     <= 1'b1;
         io.out_v0        <= io.in_v0;
         io.out_v1        <= io.in_v1;
         io.out_prs1_0    <= prs1_0;
         io.out_prs2_0    <= prs2_0;
         io.out_prs1_1    <= prs1_1;
         io.out_prs2_1    <= prs2_1;
         io.out_prd_0     <= prd0;
         io.out_prd_1     <= prd1;
         io.out_old_prd_0 <= old0;
         io.out_old_prd_1 <= old1;
      end else if (io.out_ready) begin
         io.out_valid <= 1'b0;
         io.out_v0    <= 1'b0;
         io.out_v1    <= 1'b0;
      end
`ifdef RENAME_PERF_CNT_EN
   always_ff @(posedge clock)
      if (reset) begin
         perf_stall_fl <= '0;
         perf_stall_bp <= '0;
         perf_renamed  <= '0;
      end else begin
         perf_stall_fl <= perf_stall_fl + 32'(io.in_valid & ~fl_ok);
         perf_stall_bp <= perf_stall_bp + 32'(io.in_valid & io.out_valid & ~io.out_ready);
         perf_renamed  <= perf_renamed + ((io.out_valid & io.out_ready) ? 32'(io.out_v0) + 32'(io.out_v1) : 32'd0);
      end
`endif
endmodule
